// File: rtl/decode_sequencer.sv
// decode_sequencer: top-level sequencer for the decode flow and single owner
// of the shared SRAM port. Flow: VGA display -> UART image load -> M2 (IDCT)
// -> M1 (upsample/CSC) -> back to VGA display.
// Optional feature: define SEQ_WATCHDOG_EN to bound the M2/M1 waits with a
// watchdog that returns to idle and raises a sticky error flag.
module decode_sequencer #(
  parameter int UART_TIMEOUT = 50000000,
  parameter int WDOG_CYCLES  = 33554431,
  parameter int ADDR_W       = 18
) (
  input  logic              Clock_50,
  input  logic              Resetn,
  input  logic              UART_RX_I,
  output logic              UART_rx_initialize,
  output logic              UART_rx_enable,
  output logic              start_M2,
  output logic              start_M1,
  input  logic              finish_M2,
  input  logic              finish_M1,
  output logic              VGA_enable,
  output logic [1:0]        owner,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic [ADDR_W-1:0] UART_SRAM_address,
  input  logic [15:0]       UART_SRAM_write_data,
  input  logic              UART_SRAM_we_n,
  input  logic [ADDR_W-1:0] M2_SRAM_address,
  input  logic [15:0]       M2_SRAM_write_data,
  input  logic              M2_SRAM_we_n,
  input  logic [ADDR_W-1:0] M1_SRAM_address,
  input  logic [15:0]       M1_SRAM_write_data,
  input  logic              M1_SRAM_we_n,
  input  logic [ADDR_W-1:0] VGA_SRAM_address,
  output logic [ADDR_W-1:0] SRAM_address,
  output logic [15:0]       SRAM_write_data,
  output logic              SRAM_we_n
);

  // One timer serves both the UART inactivity count and the watchdog.
  localparam int TIMER_MAX = (UART_TIMEOUT > WDOG_CYCLES) ? UART_TIMEOUT : WDOG_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam logic [TIMER_W-1:0] UART_LAST = TIMER_W'(UART_TIMEOUT - 1);
`ifdef SEQ_WATCHDOG_EN
  localparam logic [TIMER_W-1:0] WDOG_LAST = TIMER_W'(WDOG_CYCLES);
`endif

  // State encoding doubles as the SRAM owner code.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_UART_RX = 2'd1,
    S_M2_WAIT = 2'd2,
    S_M1_WAIT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               init_q, init_d;
  logic               rx_en_q, rx_en_d;
  logic               start_m2_q, start_m2_d;
  logic               start_m1_q, start_m1_d;
  logic               done_q, done_d;
  logic               vga_en_q, vga_en_d;
  logic               error_q, error_d;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    timer_d    = timer_q;
    init_d     = 1'b0;
    rx_en_d    = 1'b0;
    start_m2_d = 1'b0;
    start_m1_d = 1'b0;
    done_d     = 1'b0;
    vga_en_d   = vga_en_q;
    error_d    = error_q;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!UART_RX_I) begin
          state_d  = S_UART_RX;
          init_d   = 1'b1;
          vga_en_d = 1'b0;
          error_d  = 1'b0;
        end
      end
      S_UART_RX: begin
        rx_en_d = init_q;
        // A fresh UART write restarts the idle count even at the terminal value.
        if (!UART_SRAM_we_n) begin
          timer_d = '0;
        end else if (timer_q == UART_LAST) begin
          state_d    = S_M2_WAIT;
          start_m2_d = 1'b1;
          timer_d    = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_M2_WAIT: begin
        if (finish_M2) begin
          state_d    = S_M1_WAIT;
          start_m1_d = 1'b1;
          timer_d    = '0;
        end
`ifdef SEQ_WATCHDOG_EN
        else if (timer_q == WDOG_LAST) begin
          state_d  = S_IDLE;
          error_d  = 1'b1;
          vga_en_d = 1'b1;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
      S_M1_WAIT: begin
        if (finish_M1) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          vga_en_d = 1'b1;
          timer_d  = '0;
        end
`ifdef SEQ_WATCHDOG_EN
        else if (timer_q == WDOG_LAST) begin
          state_d  = S_IDLE;
          error_d  = 1'b1;
          vga_en_d = 1'b1;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d  = S_IDLE;
        timer_d  = '0;
        vga_en_d = 1'b1;
      end
    endcase
  end

  // Sequencer registers: state, timer and all registered handshake outputs.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      init_q     <= 1'b0;
      rx_en_q    <= 1'b0;
      start_m2_q <= 1'b0;
      start_m1_q <= 1'b0;
      done_q     <= 1'b0;
      vga_en_q   <= 1'b1;
      error_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      timer_q    <= timer_d;
      init_q     <= init_d;
      rx_en_q    <= rx_en_d;
      start_m2_q <= start_m2_d;
      start_m1_q <= start_m1_d;
      done_q     <= done_d;
      vga_en_q   <= vga_en_d;
      error_q    <= error_d;
    end
  end

  assign UART_rx_initialize = init_q;
  assign UART_rx_enable     = rx_en_q;
  assign start_M2           = start_m2_q;
  assign start_M1           = start_m1_q;
  assign done               = done_q;
  assign VGA_enable         = vga_en_q;
  assign error              = error_q;
  assign owner              = state_q;
  assign busy               = (state_q != S_IDLE);

  // SRAM port mux: exactly one requester drives the port, chosen by owner.
  always_comb begin
    SRAM_address    = VGA_SRAM_address;
    SRAM_write_data = 16'h0000;
    SRAM_we_n       = 1'b1;
    case (owner)
      2'd1: begin
        SRAM_address    = UART_SRAM_address;
        SRAM_write_data = UART_SRAM_write_data;
        SRAM_we_n       = UART_SRAM_we_n;
      end
      2'd2: begin
        SRAM_address    = M2_SRAM_address;
        SRAM_write_data = M2_SRAM_write_data;
        SRAM_we_n       = M2_SRAM_we_n;
      end
      2'd3: begin
        SRAM_address    = M1_SRAM_address;
        SRAM_write_data = M1_SRAM_write_data;
        SRAM_we_n       = M1_SRAM_we_n;
      end
      default: begin
        SRAM_address    = VGA_SRAM_address;
        SRAM_write_data = 16'h0000;
        SRAM_we_n       = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_decode_sequencer.sv
// Testbench for decode_sequencer. Pulse outputs are scoreboarded: the expected
// pulse kind and cycle are queued when stimulus is driven and popped when the
// DUT pulses. Level outputs are checked directly at directed points.
// Build with SEQ_WATCHDOG_EN defined to also exercise the watchdog.
module tb_decode_sequencer;

  localparam int UART_TIMEOUT = 100;
  localparam int WDOG_CYCLES  = 500;
  localparam int ADDR_W       = 18;

  localparam logic [ADDR_W-1:0] UART_ADDR = 18'h11111;
  localparam logic [ADDR_W-1:0] M2_ADDR   = 18'h22222;
  localparam logic [ADDR_W-1:0] M1_ADDR   = 18'h33333;
  localparam logic [ADDR_W-1:0] VGA_ADDR  = 18'h00444;

  typedef enum logic [2:0] {EV_INIT, EV_EN, EV_SM2, EV_SM1, EV_DONE} ev_t;
  typedef struct {
    ev_t kind;
    int  cyc;
  } pulse_t;

  logic              Clock_50, Resetn, UART_RX_I;
  logic              UART_rx_initialize, UART_rx_enable, start_M2, start_M1;
  logic              finish_M2, finish_M1, VGA_enable, busy, done, error;
  logic [1:0]        owner;
  logic [ADDR_W-1:0] UART_SRAM_address, M2_SRAM_address, M1_SRAM_address, VGA_SRAM_address;
  logic [15:0]       UART_SRAM_write_data, M2_SRAM_write_data, M1_SRAM_write_data;
  logic              UART_SRAM_we_n, M2_SRAM_we_n, M1_SRAM_we_n;
  logic [ADDR_W-1:0] SRAM_address;
  logic [15:0]       SRAM_write_data;
  logic              SRAM_we_n;

  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  pulse_t sb[$];

  decode_sequencer #(
    .UART_TIMEOUT(UART_TIMEOUT),
    .WDOG_CYCLES (WDOG_CYCLES),
    .ADDR_W      (ADDR_W)
  ) dut (
    .Clock_50            (Clock_50),
    .Resetn              (Resetn),
    .UART_RX_I           (UART_RX_I),
    .UART_rx_initialize  (UART_rx_initialize),
    .UART_rx_enable      (UART_rx_enable),
    .start_M2            (start_M2),
    .start_M1            (start_M1),
    .finish_M2           (finish_M2),
    .finish_M1           (finish_M1),
    .VGA_enable          (VGA_enable),
    .owner               (owner),
    .busy                (busy),
    .done                (done),
    .error               (error),
    .UART_SRAM_address   (UART_SRAM_address),
    .UART_SRAM_write_data(UART_SRAM_write_data),
    .UART_SRAM_we_n      (UART_SRAM_we_n),
    .M2_SRAM_address     (M2_SRAM_address),
    .M2_SRAM_write_data  (M2_SRAM_write_data),
    .M2_SRAM_we_n        (M2_SRAM_we_n),
    .M1_SRAM_address     (M1_SRAM_address),
    .M1_SRAM_write_data  (M1_SRAM_write_data),
    .M1_SRAM_we_n        (M1_SRAM_we_n),
    .VGA_SRAM_address    (VGA_SRAM_address),
    .SRAM_address        (SRAM_address),
    .SRAM_write_data     (SRAM_write_data),
    .SRAM_we_n           (SRAM_we_n)
  );

  initial begin
    Clock_50 = 1'b0;
    forever #5 Clock_50 = ~Clock_50;
  end

  // Cycle index: number of rising edges seen so far.
  always @(posedge Clock_50) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clock_50);
  endtask

  task automatic expect_pulse(input ev_t kind, input int at_cyc);
    pulse_t p;
    p.kind = kind;
    p.cyc  = at_cyc;
    sb.push_back(p);
  endtask

  // Pop the oldest expected pulse and compare it with what the DUT produced.
  task automatic sb_match(input ev_t kind);
    pulse_t p;
    check("pulse_was_expected", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      p = sb.pop_front();
      check("pulse_kind", 32'(kind), 32'(p.kind));
      check("pulse_cycle", 32'(cyc), 32'(p.cyc));
    end
  endtask

  task automatic check_drained(input string tag);
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  // Drive one UART write strobe, sampled at the next rising edge.
  task automatic uart_write();
    UART_SRAM_we_n = 1'b0;
    tick(1);
    UART_SRAM_we_n = 1'b1;
  endtask

  // Pulse monitor: every one-cycle pulse must match the scoreboard head.
  always @(negedge Clock_50) begin
    if (Resetn) begin
      if (UART_rx_initialize) sb_match(EV_INIT);
      if (UART_rx_enable)     sb_match(EV_EN);
      if (start_M2)           sb_match(EV_SM2);
      if (start_M1)           sb_match(EV_SM1);
      if (done)               sb_match(EV_DONE);
    end
  end

  initial begin
    int n0;
    int w;
    int s;
    Resetn               = 1'b0;
    UART_RX_I            = 1'b1;
    finish_M2            = 1'b0;
    finish_M1            = 1'b0;
    UART_SRAM_address    = UART_ADDR;
    M2_SRAM_address      = M2_ADDR;
    M1_SRAM_address      = M1_ADDR;
    VGA_SRAM_address     = VGA_ADDR;
    UART_SRAM_write_data = 16'hAAAA;
    M2_SRAM_write_data   = 16'hBBBB;
    M1_SRAM_write_data   = 16'hCCCC;
    UART_SRAM_we_n       = 1'b1;
    M2_SRAM_we_n         = 1'b0;
    M1_SRAM_we_n         = 1'b0;

    // Reset values.
    tick(3);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_vga_enable", 32'(VGA_enable), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", 32'({UART_rx_initialize, UART_rx_enable, start_M2, start_M1, done}), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    Resetn = 1'b1;

    // Idle with the UART line high: VGA owns the SRAM.
    tick(100);
    check("idle_owner", 32'(owner), 32'd0);
    check("idle_vga_enable", 32'(VGA_enable), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_sram_we_n", 32'(SRAM_we_n), 32'd1);
    check("idle_sram_addr", 32'(SRAM_address), 32'(VGA_ADDR));
    check("idle_sram_wdata", 32'(SRAM_write_data), 32'd0);

    // Finish flags are ignored in idle.
    finish_M1 = 1'b1;
    finish_M2 = 1'b1;
    tick(1);
    finish_M1 = 1'b0;
    finish_M2 = 1'b0;
    tick(2);
    check("idle_ignores_finish_owner", 32'(owner), 32'd0);
    check("idle_ignores_finish_busy", 32'(busy), 32'd0);

    // Load 1: start bit, writes at +10, +50, +140, timeout after the last one.
    n0 = cyc;
    UART_RX_I = 1'b0;
    expect_pulse(EV_INIT, n0 + 1);
    expect_pulse(EV_EN, n0 + 2);
    tick(1);
    UART_RX_I = 1'b1;
    check("load_owner", 32'(owner), 32'd1);
    check("load_busy", 32'(busy), 32'd1);
    check("load_vga_enable", 32'(VGA_enable), 32'd0);
    check("load_sram_addr", 32'(SRAM_address), 32'(UART_ADDR));
    tick(n0 + 10 - cyc);
    UART_SRAM_we_n = 1'b0;
    #1;
    check("load_sram_we_n", 32'(SRAM_we_n), 32'd0);
    check("load_sram_wdata", 32'(SRAM_write_data), 32'hAAAA);
    tick(1);
    UART_SRAM_we_n = 1'b1;
    tick(n0 + 50 - cyc);
    uart_write();
    tick(n0 + 140 - cyc);
    w = cyc;
    uart_write();
    expect_pulse(EV_SM2, w + 101);
    tick(w + 100 - cyc);
    check("owner_before_m2", 32'(owner), 32'd1);

    // M2 finishes in the very cycle start_M2 is high.
    tick(1);
    check("m2_owner", 32'(owner), 32'd2);
    check("m2_sram_addr", 32'(SRAM_address), 32'(M2_ADDR));
    check("m2_sram_we_n", 32'(SRAM_we_n), 32'd0);
    finish_M2 = 1'b1;
    expect_pulse(EV_SM1, cyc + 1);
    tick(1);
    finish_M2 = 1'b0;
    check("m1_owner", 32'(owner), 32'd3);
    check("m1_sram_addr", 32'(SRAM_address), 32'(M1_ADDR));
    tick(19);
    finish_M1 = 1'b1;
    expect_pulse(EV_DONE, cyc + 1);
    tick(1);
    finish_M1 = 1'b0;
    check("done_owner", 32'(owner), 32'd0);
    check("done_vga_enable", 32'(VGA_enable), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_sram_addr", 32'(SRAM_address), 32'(VGA_ADDR));
    check("done_sram_we_n", 32'(SRAM_we_n), 32'd1);
    check("done_error", 32'(error), 32'd0);
    tick(2);
    check_drained("load1_pulses_drained");

    // Load 2: a write coinciding with timer==UART_TIMEOUT-1 restarts the count.
    n0 = cyc;
    UART_RX_I = 1'b0;
    expect_pulse(EV_INIT, n0 + 1);
    expect_pulse(EV_EN, n0 + 2);
    tick(1);
    UART_RX_I = 1'b1;
    tick(4);
    w = cyc;
    uart_write();
    tick(w + 100 - cyc);
    check("owner_at_terminal", 32'(owner), 32'd1);
    UART_SRAM_we_n = 1'b0;
    tick(1);
    UART_SRAM_we_n = 1'b1;
    check("no_start_on_collision", 32'(owner), 32'd1);
    expect_pulse(EV_SM2, w + 201);
    tick(w + 200 - cyc);
    check("owner_before_restart_timeout", 32'(owner), 32'd1);
    tick(1);
    check("m2_after_restart", 32'(owner), 32'd2);

    // Reset mid-M2: everything reverts at once, no start_M1 or done.
    tick(2);
    finish_M2 = 1'b1;
    Resetn    = 1'b0;
    #1;
    check("midrst_owner", 32'(owner), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sram_addr", 32'(SRAM_address), 32'(VGA_ADDR));
    check("midrst_sram_we_n", 32'(SRAM_we_n), 32'd1);
    check("midrst_vga_enable", 32'(VGA_enable), 32'd1);
    check("midrst_start_m1", 32'(start_M1), 32'd0);
    tick(3);
    finish_M2 = 1'b0;
    Resetn    = 1'b1;
    tick(5);
    check("post_rst_owner", 32'(owner), 32'd0);
    check_drained("midrst_pulses_drained");

`ifdef SEQ_WATCHDOG_EN
    // Watchdog expiry in M2_WAIT with finish_M2 held low.
    n0 = cyc;
    UART_RX_I = 1'b0;
    expect_pulse(EV_INIT, n0 + 1);
    expect_pulse(EV_EN, n0 + 2);
    tick(1);
    UART_RX_I = 1'b1;
    s = n0 + 101;
    expect_pulse(EV_SM2, s);
    tick(s + 500 - cyc);
    check("wdog_owner_before", 32'(owner), 32'd2);
    check("wdog_error_before", 32'(error), 32'd0);
    tick(1);
    check("wdog_owner_after", 32'(owner), 32'd0);
    check("wdog_error_after", 32'(error), 32'd1);
    check("wdog_vga_enable", 32'(VGA_enable), 32'd1);
    tick(3);
    check("wdog_error_sticky", 32'(error), 32'd1);
    check_drained("wdog_no_done");

    // Next start bit clears error; finish on the expiry cycle wins.
    n0 = cyc;
    UART_RX_I = 1'b0;
    expect_pulse(EV_INIT, n0 + 1);
    expect_pulse(EV_EN, n0 + 2);
    tick(1);
    UART_RX_I = 1'b1;
    check("wdog_error_cleared", 32'(error), 32'd0);
    s = n0 + 101;
    expect_pulse(EV_SM2, s);
    tick(s + 500 - cyc);
    finish_M2 = 1'b1;
    expect_pulse(EV_SM1, s + 501);
    tick(1);
    finish_M2 = 1'b0;
    check("wdog_race_owner", 32'(owner), 32'd3);
    check("wdog_race_error", 32'(error), 32'd0);
    tick(3);
    finish_M1 = 1'b1;
    expect_pulse(EV_DONE, cyc + 1);
    tick(1);
    finish_M1 = 1'b0;
    check("wdog_race_done_owner", 32'(owner), 32'd0);
    check("wdog_race_done_error", 32'(error), 32'd0);
`else
    // Without the watchdog, a long M2 wait never times out.
    n0 = cyc;
    UART_RX_I = 1'b0;
    expect_pulse(EV_INIT, n0 + 1);
    expect_pulse(EV_EN, n0 + 2);
    tick(1);
    UART_RX_I = 1'b1;
    s = n0 + 101;
    expect_pulse(EV_SM2, s);
    tick(s + WDOG_CYCLES + 50 - cyc);
    check("nowdog_still_waiting", 32'(owner), 32'd2);
    check("nowdog_error", 32'(error), 32'd0);
    finish_M2 = 1'b1;
    expect_pulse(EV_SM1, cyc + 1);
    tick(1);
    finish_M2 = 1'b0;
    finish_M1 = 1'b1;
    expect_pulse(EV_DONE, cyc + 1);
    tick(1);
    finish_M1 = 1'b0;
    check("nowdog_done_owner", 32'(owner), 32'd0);
`endif

    tick(3);
    check_drained("final_pulses_drained");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
